// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306 frame scheduler: FSM states,
// controller opcodes and header geometry.
package ssd1306_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_USER_CMD,
        S_HDR,
        S_FETCH,
        S_CAPTURE,
        S_SEND_DATA
    } state_t;

    localparam logic [7:0] CMD_SET_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_SET_PAGE_ADDR = 8'h22;
    localparam logic [7:0] CMD_DISPLAY_OFF   = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON    = 8'hAF;
    localparam logic [7:0] CMD_SET_CONTRAST  = 8'h81;

    localparam int HDR_LEN   = 6;
    localparam int HDR_IDX_W = 3;

endpackage

// File: rtl/ssd1306_frame_scheduler_if.sv
// Signal bundle between the frame scheduler and its surroundings:
// refresh/command requesters, framebuffer read port and SPI byte engine.
interface ssd1306_frame_scheduler_if #(
    parameter int FB_AW = 10
);
    logic             refresh_req;
    logic             cmd_req;
    logic [7:0]       cmd_byte;
    logic             cmd_ack;
    logic [FB_AW-1:0] fb_addr;
    logic [7:0]       fb_data;
    logic             tx_valid;
    logic [7:0]       tx_byte;
    logic             tx_dc;
    logic             tx_ready;
    logic             busy;
    logic             frame_done;

    modport master (
        input  refresh_req, cmd_req, cmd_byte, fb_data, tx_ready,
        output cmd_ack, fb_addr, tx_valid, tx_byte, tx_dc, busy, frame_done
    );

    modport slave (
        output refresh_req, cmd_req, cmd_byte, fb_data, tx_ready,
        input  cmd_ack, fb_addr, tx_valid, tx_byte, tx_dc, busy, frame_done
    );

endinterface

// File: rtl/ssd1306_hdr_rom.sv
// Address-window header sent ahead of every frame: full column range, then
// full page range, sized by the panel geometry.
module ssd1306_hdr_rom
    import ssd1306_pkg::*;
#(
    parameter int COLS  = 128,
    parameter int PAGES = 8
) (
    input  logic [HDR_IDX_W-1:0] idx,
    output logic [7:0]           hdr_byte
);

    always_comb begin
        hdr_byte = 8'h00;
        case (idx)
            3'd0:    hdr_byte = CMD_SET_COL_ADDR;
            3'd1:    hdr_byte = 8'h00;
            3'd2:    hdr_byte = 8'(COLS - 1);
            3'd3:    hdr_byte = CMD_SET_PAGE_ADDR;
            3'd4:    hdr_byte = 8'h00;
            3'd5:    hdr_byte = 8'(PAGES - 1);
            default: hdr_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/ssd1306_frame_scheduler.sv
// Streams full SSD1306 frames (header + framebuffer) and one-off command
// bytes onto a shared SPI byte transmitter; commands never interrupt a frame.
module ssd1306_frame_scheduler
    import ssd1306_pkg::*;
#(
    parameter int COLS  = 128,
    parameter int PAGES = 8,
    parameter int FB_AW = $clog2(COLS * PAGES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ssd1306_frame_scheduler_if.master  bus
);

    localparam logic [FB_AW-1:0]     LAST_ADDR = FB_AW'(COLS * PAGES - 1);
    localparam logic [HDR_IDX_W-1:0] HDR_LAST  = HDR_IDX_W'(HDR_LEN - 1);

    state_t               state;
    logic                 pending;
    logic [HDR_IDX_W-1:0] hdr_idx;
    logic [HDR_IDX_W-1:0] rom_idx;
    logic [7:0]           rom_byte;
    logic                 xfer;

    assign xfer = bus.tx_valid && bus.tx_ready;

    // The ROM looks one entry ahead so the next header byte is ready to
    // register on the transfer of the current one.
    assign rom_idx = (state == S_HDR) ? hdr_idx + HDR_IDX_W'(1) : '0;

    ssd1306_hdr_rom #(
        .COLS  (COLS),
        .PAGES (PAGES)
    ) u_hdr_rom (
        .idx      (rom_idx),
        .hdr_byte (rom_byte)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pending        <= 1'b0;
            hdr_idx        <= '0;
            bus.tx_valid   <= 1'b0;
            bus.tx_byte    <= 8'h00;
            bus.tx_dc      <= 1'b0;
            bus.fb_addr    <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.cmd_ack    <= 1'b0;
        end else begin
            bus.cmd_ack    <= 1'b0;
            bus.frame_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Skip the cycle the ack is visible so a requester still
                    // holding cmd_req is not served twice.
                    if (!bus.cmd_ack) begin
                        if (bus.cmd_req) begin
                            state        <= S_USER_CMD;
                            bus.busy     <= 1'b1;
                            bus.tx_valid <= 1'b1;
                            bus.tx_dc    <= 1'b0;
                            bus.tx_byte  <= bus.cmd_byte;
                        end else if (pending) begin
                            state        <= S_HDR;
                            bus.busy     <= 1'b1;
                            pending      <= 1'b0;
                            hdr_idx      <= '0;
                            bus.tx_valid <= 1'b1;
                            bus.tx_dc    <= 1'b0;
                            bus.tx_byte  <= rom_byte;
                        end
                    end
                end

                S_USER_CMD: begin
                    if (xfer) begin
                        state        <= S_IDLE;
                        bus.busy     <= 1'b0;
                        bus.tx_valid <= 1'b0;
                        bus.cmd_ack  <= 1'b1;
                    end
                end

                S_HDR: begin
                    if (xfer) begin
                        if (hdr_idx == HDR_LAST) begin
                            state        <= S_FETCH;
                            bus.tx_valid <= 1'b0;
                            bus.fb_addr  <= '0;
                        end else begin
                            hdr_idx     <= hdr_idx + HDR_IDX_W'(1);
                            bus.tx_byte <= rom_byte;
                        end
                    end
                end

                S_FETCH: begin
                    state <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    state        <= S_SEND_DATA;
                    bus.tx_byte  <= bus.fb_data;
                    bus.tx_dc    <= 1'b1;
                    bus.tx_valid <= 1'b1;
                end

                S_SEND_DATA: begin
                    if (xfer) begin
                        bus.tx_valid <= 1'b0;
                        if (bus.fb_addr == LAST_ADDR) begin
                            state          <= S_IDLE;
                            bus.busy       <= 1'b0;
                            bus.frame_done <= 1'b1;
                        end else begin
                            state       <= S_FETCH;
                            bus.fb_addr <= bus.fb_addr + FB_AW'(1);
                        end
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    bus.busy     <= 1'b0;
                    bus.tx_valid <= 1'b0;
                end
            endcase

            // Last assignment wins, so a pulse coinciding with the clear re-arms it.
            if (bus.refresh_req) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssd1306_frame_scheduler.sv
// Bench for the SSD1306 frame scheduler: framebuffer RAM model, transfer
// monitor and a stream-level reference of what each frame/command must send.
module tb_ssd1306_frame_scheduler;

    localparam int COLS  = 128;
    localparam int PAGES = 8;
    localparam int NB    = COLS * PAGES;
    localparam int FB_AW = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ssd1306_frame_scheduler_if #(.FB_AW(FB_AW)) bus();

    ssd1306_frame_scheduler #(
        .COLS  (COLS),
        .PAGES (PAGES),
        .FB_AW (FB_AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rnd_ready = 1'b0;

    logic [7:0] fb_mem [NB];
    always @(posedge clk) bus.fb_data <= fb_mem[bus.fb_addr];
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       dc;
        logic [7:0] b;
    } tx_t;

    tx_t  obs_q[$];
    int   obs_t[$];
    tx_t  exp_q[$];
    int   done_cnt, done_t, ack_cnt, ack_t, hold_err;
    logic pv, pd;
    logic [7:0] pb;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (pv && !(bus.tx_valid && bus.tx_byte == pb && bus.tx_dc == pd)) hold_err++;
            pv = bus.tx_valid && !bus.tx_ready;
            pb = bus.tx_byte;
            pd = bus.tx_dc;
            if (bus.tx_valid && bus.tx_ready) begin
                obs_q.push_back({bus.tx_dc, bus.tx_byte});
                obs_t.push_back(cyc);
            end
            if (bus.frame_done) begin done_cnt++; done_t = cyc; end
            if (bus.cmd_ack)    begin ack_cnt++;  ack_t  = cyc; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) bus.tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    function automatic void clear_obs();
        obs_q.delete();
        obs_t.delete();
        exp_q.delete();
        done_cnt = 0;
        ack_cnt  = 0;
        hold_err = 0;
    endfunction

    // What a frame must look like on the wire: window header then every pixel byte in address order.
    function automatic void exp_frame();
        logic [7:0] hdr [6];
        hdr = '{8'h21, 8'h00, 8'(COLS - 1), 8'h22, 8'h00, 8'(PAGES - 1)};
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, hdr[i]});
        for (int a = 0; a < NB; a++) exp_q.push_back({1'b1, fb_mem[a]});
    endfunction

    function automatic void exp_cmd(input logic [7:0] c);
        exp_q.push_back({1'b0, c});
    endfunction

    function automatic int stream_mismatch();
        int m, n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        m = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size() : exp_q.size() - obs_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) m++;
        return m;
    endfunction

    function automatic void fill_fb(input bit pattern);
        for (int a = 0; a < NB; a++) fb_mem[a] = pattern ? (8'(a) ^ 8'h5A) : 8'($urandom);
    endfunction

    task automatic pulse_refresh();
        bus.refresh_req = 1'b1;
        tick();
        bus.refresh_req = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, output bit timed_out);
        int k = 0;
        while (done_cnt < n && k < budget) begin tick(); k++; end
        timed_out = (done_cnt < n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.tx_valid, bus.tx_dc, bus.busy, bus.frame_done, bus.cmd_ack} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got v=%b dc=%b busy=%b done=%b ack=%b want all 0",
                     bus.tx_valid, bus.tx_dc, bus.busy, bus.frame_done, bus.cmd_ack);
        end
        checks++;
        if (bus.tx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", bus.tx_byte); end
        checks++;
        if (bus.fb_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus.fb_addr); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got busy=%b valid=%b want 0 0", bus.busy, bus.tx_valid);
        end
    endtask

    task automatic test_single_refresh();
        bit to;
        int gaps = 0;
        fill_fb(1'b1);
        clear_obs();
        exp_frame();
        pulse_refresh();
        wait_done(1, 5000, to);
        repeat (5) tick();
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout got done=%0d want 1", done_cnt); end
        checks++;
        if (stream_mismatch() !== 0) begin
            errors++;
            $display("FAIL single_stream got %0d bytes with %0d mismatches want %0d exact", obs_q.size(), stream_mismatch(), exp_q.size());
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL single_done_count got %0d want 1", done_cnt); end
        if (obs_t.size() > 0) begin
            checks++;
            if (done_t - obs_t[0] !== 6 + 3 * NB) begin
                errors++;
                $display("FAIL single_latency got %0d want %0d", done_t - obs_t[0], 6 + 3 * NB);
            end
        end
        for (int i = 7; i < obs_t.size(); i++) if (obs_t[i] - obs_t[i-1] != 3) gaps++;
        checks++;
        if (gaps !== 0) begin errors++; $display("FAIL single_data_gaps got %0d bad gaps want 0", gaps); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_backpressure();
        bit to, found;
        int k = 0;
        logic [7:0] held;
        fill_fb(1'b0);
        clear_obs();
        exp_frame();
        pulse_refresh();
        found = 1'b0;
        while (!found && k < 500) begin
            tick();
            k++;
            found = bus.tx_valid && bus.tx_dc && obs_q.size() == 6 + 10;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL bp_reach_byte10 got %0d transfers want 16", obs_q.size()); end
        bus.tx_ready = 1'b0;
        held = bus.tx_byte;
        checks++;
        if (held !== fb_mem[10]) begin errors++; $display("FAIL bp_byte10_value got %h want %h", held, fb_mem[10]); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_dc !== 1'b1 || bus.tx_byte !== fb_mem[10]) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b dc=%b byte=%h want 1 1 %h", i, bus.tx_valid, bus.tx_dc, bus.tx_byte, fb_mem[10]);
            end
        end
        bus.tx_ready = 1'b1;
        wait_done(1, 5000, to);
        repeat (5) tick();
        checks++;
        if (to || done_cnt !== 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
        checks++;
        if (stream_mismatch() !== 0) begin errors++; $display("FAIL bp_stream got %0d mismatches want 0", stream_mismatch()); end
        checks++;
        if (hold_err !== 0) begin errors++; $display("FAIL bp_monitor_hold got %0d violations want 0", hold_err); end
    endtask

    task automatic test_arbitration();
        bit to;
        int k;
        logic [7:0] c;
        // Command and refresh on the same idle cycle: command first.
        fill_fb(1'b0);
        clear_obs();
        exp_cmd(8'h81);
        exp_frame();
        bus.cmd_req     = 1'b1;
        bus.cmd_byte    = 8'h81;
        bus.refresh_req = 1'b1;
        tick();
        bus.refresh_req = 1'b0;
        k = 0;
        while (!bus.cmd_ack && k < 50) begin tick(); k++; end
        bus.cmd_req = 1'b0;
        wait_done(1, 5000, to);
        repeat (5) tick();
        checks++;
        if (ack_cnt !== 1) begin errors++; $display("FAIL arb_same_ack_count got %0d want 1", ack_cnt); end
        checks++;
        if (to || stream_mismatch() !== 0) begin errors++; $display("FAIL arb_same_stream got %0d mismatches want 0", stream_mismatch()); end
        if (obs_t.size() > 1) begin
            checks++;
            if (!(ack_t < obs_t[1])) begin errors++; $display("FAIL arb_same_order got ack@%0d hdr@%0d want ack first", ack_t, obs_t[1]); end
        end

        // Command raised mid-frame waits for the frame to finish.
        fill_fb(1'b0);
        clear_obs();
        c = ($urandom_range(0, 1) != 0) ? 8'hAE : 8'hAF;
        exp_frame();
        exp_cmd(c);
        pulse_refresh();
        repeat ($urandom_range(50, 2000)) tick();
        bus.cmd_req  = 1'b1;
        bus.cmd_byte = c;
        k = 0;
        while (!bus.cmd_ack && k < 5000) begin tick(); k++; end
        bus.cmd_req = 1'b0;
        repeat (5) tick();
        checks++;
        if (ack_cnt !== 1 || done_cnt !== 1) begin
            errors++;
            $display("FAIL arb_mid_counts got ack=%0d done=%0d want 1 1", ack_cnt, done_cnt);
        end
        checks++;
        if (!(ack_t > done_t)) begin errors++; $display("FAIL arb_mid_order got ack@%0d done@%0d want ack after done", ack_t, done_t); end
        checks++;
        if (stream_mismatch() !== 0) begin errors++; $display("FAIL arb_mid_stream got %0d mismatches want 0", stream_mismatch()); end
    endtask

    task automatic test_pending();
        bit to;
        fill_fb(1'b0);
        clear_obs();
        exp_frame();
        exp_frame();
        rnd_ready = 1'b1;
        pulse_refresh();
        for (int p = 0; p < 3; p++) begin
            repeat ($urandom_range(50, 500)) tick();
            pulse_refresh();
        end
        wait_done(2, 30000, to);
        repeat (20) tick();
        rnd_ready    = 1'b0;
        bus.tx_ready = 1'b1;
        checks++;
        if (to || done_cnt !== 2) begin errors++; $display("FAIL pend_frames got %0d want 2", done_cnt); end
        checks++;
        if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL pend_idle got busy=%b valid=%b want 0 0", bus.busy, bus.tx_valid);
        end
        checks++;
        if (stream_mismatch() !== 0) begin errors++; $display("FAIL pend_stream got %0d mismatches want 0", stream_mismatch()); end
        checks++;
        if (hold_err !== 0) begin errors++; $display("FAIL pend_hold got %0d violations want 0", hold_err); end
    endtask

    task automatic test_reset_mid_frame();
        bit to, found;
        int k = 0;
        fill_fb(1'b0);
        clear_obs();
        pulse_refresh();
        found = 1'b0;
        while (!found && k < 3000) begin
            tick();
            k++;
            found = bus.tx_valid && bus.tx_dc && obs_q.size() == 6 + 500;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_reach got %0d transfers want 506", obs_q.size()); end
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.fb_addr !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state got v=%b addr=%0d busy=%b want 0 0 0", bus.tx_valid, bus.fb_addr, bus.busy);
        end
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", done_cnt); end
        clear_obs();
        exp_frame();
        pulse_refresh();
        wait_done(1, 5000, to);
        repeat (5) tick();
        checks++;
        if (obs_q.size() == 0 || obs_q[0] !== {1'b0, 8'h21}) begin
            errors++;
            $display("FAIL rstmid_restart_first got %h want 021", (obs_q.size() > 0) ? obs_q[0] : 9'h1FF);
        end
        checks++;
        if (to || done_cnt !== 1 || stream_mismatch() !== 0) begin
            errors++;
            $display("FAIL rstmid_restart_frame got done=%0d mismatches=%0d want 1 0", done_cnt, stream_mismatch());
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.refresh_req = 1'b0;
        bus.cmd_req     = 1'b0;
        bus.cmd_byte    = 8'h00;
        bus.tx_ready    = 1'b1;
        fill_fb(1'b1);
        clear_obs();
        test_reset();
        test_single_refresh();
        test_backpressure();
        test_arbitration();
        test_pending();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
